// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants and types for the fetch queue unit.
// Optional compressed-instruction support is enabled by defining FQU_RVC_EN.
package fetch_queue_unit_pkg;

   localparam int unsigned XLEN          = 32;
   localparam int unsigned REG_NUM_WIDTH = 5;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // RVC quadrants and funct3 codes of the control-flow instructions
   localparam logic [1:0] RVC_Q1      = 2'b01;
   localparam logic [1:0] RVC_Q2      = 2'b10;
   localparam logic [2:0] C_F3_JAL    = 3'b001;
   localparam logic [2:0] C_F3_J      = 3'b101;
   localparam logic [2:0] C_F3_BEQZ   = 3'b110;
   localparam logic [2:0] C_F3_BNEZ   = 3'b111;
   localparam logic [2:0] C_F3_JR     = 3'b100;

   typedef enum logic {
      FETCH    = 1'b0,
      WAIT_REG = 1'b1
   } fq_state_e;

   typedef enum logic [1:0] {
      CLS_OTHER  = 2'd0,
      CLS_JAL    = 2'd1,
      CLS_BRANCH = 2'd2,
      CLS_JALR   = 2'd3
   } fq_cls_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            taken;
      logic [XLEN-1:0] target;
      logic            is_rvc;
   } fq_entry_t;

endpackage

// File: rtl/fq_predecode.sv
// Combinational predecode: classifies a fetched word and computes its target and next PC.
// Compressed decoding is present only when FQU_RVC_EN is defined.
module fq_predecode
   import fetch_queue_unit_pkg::*;
(
   input  logic [XLEN-1:0]          instr,
   input  logic [XLEN-1:0]          pc,
   input  logic [XLEN-1:0]          rf_value,
   input  logic                     pred_taken,
   output logic                     is_rvc,
   output fq_cls_e                  cls,
   output logic [XLEN-1:0]          target,
   output logic [XLEN-1:0]          next_pc,
   output logic                     taken,
   output logic [REG_NUM_WIDTH-1:0] rs
);

   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] seq_pc;

   // Instruction class, sign-extended immediate and JALR source register
   always_comb begin
      is_rvc = 1'b0;
      cls    = CLS_OTHER;
      imm    = '0;
      rs     = '0;
      case (instr[6:0])
         OPC_JAL: begin
            cls = CLS_JAL;
            imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OPC_BRANCH: begin
            cls = CLS_BRANCH;
            imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OPC_JALR: begin
            cls = CLS_JALR;
            imm = {{20{instr[31]}}, instr[31:20]};
            rs  = instr[19:15];
         end
         default: ;
      endcase
`ifdef FQU_RVC_EN
      if (instr[1:0] != 2'b11) begin
         is_rvc = 1'b1;
         cls    = CLS_OTHER;
         imm    = '0;
         rs     = '0;
         if (instr[1:0] == RVC_Q1) begin
            case (instr[15:13])
               C_F3_J, C_F3_JAL: begin
                  cls = CLS_JAL;
                  imm = {{21{instr[12]}}, instr[8], instr[10:9], instr[6], instr[7],
                         instr[2], instr[11], instr[5:3], 1'b0};
               end
               C_F3_BEQZ, C_F3_BNEZ: begin
                  cls = CLS_BRANCH;
                  imm = {{24{instr[12]}}, instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};
               end
               default: ;
            endcase
         end else if (instr[1:0] == RVC_Q2 && instr[15:13] == C_F3_JR &&
                      instr[11:7] != '0 && instr[6:2] == '0) begin
            // C.JR / C.JALR: register target with no offset
            cls = CLS_JALR;
            rs  = instr[11:7];
         end
      end
`endif
   end

   // Target and next-PC selection
   always_comb begin
      seq_pc  = pc + (is_rvc ? 32'd2 : 32'd4);
      target  = pc + imm;
      next_pc = seq_pc;
      taken   = 1'b0;
      case (cls)
         CLS_JAL: begin
            next_pc = target;
            taken   = 1'b1;
         end
         CLS_BRANCH: begin
            next_pc = pred_taken ? target : seq_pc;
            taken   = pred_taken;
         end
         CLS_JALR: begin
            target  = (rf_value + imm) & ~32'd1;
            next_pc = target;
            taken   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetcher with predecode redirect, DEPTH-entry queue and JALR register wait.
// Define FQU_RVC_EN to enable 16-bit compressed instruction support.
module fetch_queue_unit
   import fetch_queue_unit_pkg::*;
#(
   parameter int unsigned DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     flush_in,
   input  logic [31:0]              flush_pc_in,
   output logic                     ic_req_out,
   output logic [31:0]              ic_pc_out,
   input  logic                     ic_valid_in,
   input  logic [31:0]              ic_instr_in,
   input  logic                     pred_taken_in,
   output logic [REG_NUM_WIDTH-1:0] rs_jalr_out,
   input  logic [31:0]              rf_jalr_value_in,
   input  logic                     rf_jalr_busy_in,
   output logic                     deq_valid_out,
   input  logic                     deq_ready_in,
   output logic [31:0]              deq_instr_out,
   output logic [31:0]              deq_pc_out,
   output logic                     deq_pred_taken_out,
   output logic [31:0]              deq_target_out,
   output logic                     deq_is_rvc_out,
   output logic [$clog2(DEPTH):0]   count_out
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fq_state_e                state_q, state_d;
   logic [31:0]              pc_q, pc_d;
   logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [31:0]              lat_instr_q, lat_instr_d, lat_pc_q, lat_pc_d;
   logic [REG_NUM_WIDTH-1:0] lat_rs_q, lat_rs_d;
   fq_entry_t                mem_q [DEPTH];
   fq_entry_t                head_entry, enq_entry;
   logic                     enq, deq;
   logic [REG_NUM_WIDTH-1:0] rs_sel;

   logic [31:0]              pd_instr, pd_pc, pd_target, pd_next_pc;
   logic                     pd_is_rvc, pd_taken;
   fq_cls_e                  pd_cls;
   logic [REG_NUM_WIDTH-1:0] pd_rs;

   // While waiting on a register, predecode re-evaluates the latched JALR
   assign pd_instr = (state_q == WAIT_REG) ? lat_instr_q : ic_instr_in;
   assign pd_pc    = (state_q == WAIT_REG) ? lat_pc_q    : pc_q;

   fq_predecode u_predecode (
      .instr      (pd_instr),
      .pc         (pd_pc),
      .rf_value   (rf_jalr_value_in),
      .pred_taken (pred_taken_in),
      .is_rvc     (pd_is_rvc),
      .cls        (pd_cls),
      .target     (pd_target),
      .next_pc    (pd_next_pc),
      .taken      (pd_taken),
      .rs         (pd_rs)
   );

   assign ic_req_out    = (state_q == FETCH) && (count_q < CNT_W'(DEPTH)) && !flush_in && !rst_in;
   assign ic_pc_out     = pc_q;
   assign rs_jalr_out   = rst_in ? '0 : rs_sel;
   assign count_out     = count_q;
   assign head_entry    = mem_q[head_q];
   assign deq_valid_out = (count_q != '0);
   assign deq_instr_out      = head_entry.instr;
   assign deq_pc_out         = head_entry.pc;
   assign deq_pred_taken_out = head_entry.taken;
   assign deq_target_out     = head_entry.target;
   assign deq_is_rvc_out     = head_entry.is_rvc;
   assign deq = deq_valid_out && deq_ready_in && rdy_in;

   always_comb begin
      enq_entry.instr  = pd_is_rvc ? {16'h0, pd_instr[15:0]} : pd_instr;
      enq_entry.pc     = pd_pc;
      enq_entry.taken  = pd_taken;
      enq_entry.target = pd_target;
      enq_entry.is_rvc = pd_is_rvc;
   end

   // Next-state, PC redirect and queue pointer logic
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      lat_instr_d = lat_instr_q;
      lat_pc_d    = lat_pc_q;
      lat_rs_d    = lat_rs_q;
      enq         = 1'b0;
      rs_sel      = '0;
      case (state_q)
         FETCH: begin
            if (ic_req_out && ic_valid_in) begin
               if (pd_cls == CLS_JALR) rs_sel = pd_rs;
               if (pd_cls == CLS_JALR && rf_jalr_busy_in) begin
                  lat_instr_d = ic_instr_in;
                  lat_pc_d    = pc_q;
                  lat_rs_d    = pd_rs;
                  state_d     = WAIT_REG;
               end else begin
                  enq  = 1'b1;
                  pc_d = pd_next_pc;
               end
            end
         end
         WAIT_REG: begin
            rs_sel = lat_rs_q;
            if (!rf_jalr_busy_in) begin
               enq     = 1'b1;
               pc_d    = pd_next_pc;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
      head_d  = head_q + PTR_W'(deq);
      tail_d  = tail_q + PTR_W'(enq);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
      if (flush_in) begin
         state_d     = FETCH;
         pc_d        = flush_pc_in;
         lat_instr_d = '0;
         lat_pc_d    = '0;
         lat_rs_d    = '0;
         enq         = 1'b0;
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         lat_instr_q <= '0;
         lat_pc_q    <= '0;
         lat_rs_q    <= '0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         lat_instr_q <= lat_instr_d;
         lat_pc_q    <= lat_pc_d;
         lat_rs_q    <= lat_rs_d;
      end
   end

   // Queue storage needs no reset; validity is tracked by count
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && enq) mem_q[tail_q] <= enq_entry;
   end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Next-generation instruction fetcher.
- Drives the I-cache PC and predecodes control-flow instructions to redirect the PC, as before.
- Adds a parametrised DEPTH-entry instruction queue, so fetch runs ahead of a stalled decoder.
- Adds a register-wait state machine for JALR/C.JR/C.JALR whose source register is still pending.
- Sits between the I-cache/branch predictor and the decoder; the ROB drives flushes.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 2.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  global enable; low freezes all state
- flush_in  in  1  ROB misprediction flush
- flush_pc_in  in  32  redirect PC on flush
- ic_req_out  out  1  fetch request this cycle
- ic_pc_out  out  32  current fetch PC (also predictor lookup PC)
- ic_valid_in  in  1  I-cache hit this cycle (combinational response)
- ic_instr_in  in  32  fetched word; low 16 bits only if compressed
- pred_taken_in  in  1  predictor result for ic_pc_out
- rs_jalr_out  out  5  register index for JALR-class read; 0 otherwise
- rf_jalr_value_in  in  32  register value
- rf_jalr_busy_in  in  1  register has an outstanding producer
- deq_valid_out  out  1  queue head valid
- deq_ready_in  in  1  decoder accepts head
- deq_instr_out  out  32  head instruction
- deq_pc_out  out  32  head PC
- deq_pred_taken_out  out  1  head predicted/forced taken
- deq_target_out  out  32  head computed target
- deq_is_rvc_out  out  1  head is 16-bit
- count_out  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset: pc=RESET_PC; queue empty (head=tail=count=0); state FETCH; latch cleared.
- Reset outputs: deq_valid_out=0, ic_req_out=0 during reset, count_out=0, rs_jalr_out=0.
- Priority: rst_in > !rdy_in (hold everything) > flush_in > normal operation.
- Flush: queue emptied, state=FETCH, pc=flush_pc_in; deq_valid_out=0 the next cycle; a same-cycle dequeue is discarded.
- ic_req_out = state==FETCH && count<DEPTH && !flush_in.
- Full rule: uses registered count, so no enqueue when full even if a dequeue happens the same cycle.
- Enqueue: ic_req_out && ic_valid_in; entry = {instr, pc, taken, target, is_rvc}; tail++ (mod DEPTH).
- Dequeue: deq_valid_out && deq_ready_in && rdy_in; head++.
- Simultaneous enqueue and dequeue: count unchanged.
- deq_* outputs are combinational from the head entry; deq_valid_out = count!=0.
- Targets: immediates sign-extended to 32 bits; all PC arithmetic mod 2^32.
- Next PC by instruction class:
  - JAL / C.J / C.JAL: pc+imm, taken=1.
  - B-type / C.BEQZ / C.BNEZ: target pc+imm always recorded; next pc = pred_taken_in ? target : pc+len; taken=pred_taken_in.
  - JALR: target (rf+imm12) & ~1. C.JR/C.JALR: target rf & ~1. taken=1.
  - Other instructions: pc+len, len = 4 or 2.
- JALR class when rf_jalr_busy_in=1: no enqueue; latch instr, pc and rs; state=WAIT_REG; ic_req_out=0.
- In WAIT_REG: rs_jalr_out driven from the latch. When busy=0: enqueue the latched entry with the computed target, pc=target, state=FETCH.
- Space in WAIT_REG is guaranteed, because count cannot rise while waiting.
- Flush in WAIT_REG returns to FETCH and drops the latch.
- ic_valid_in=0: no enqueue, pc holds.

Optional Feature:
- FQU_RVC_EN defined: 16-bit instructions decoded (low bits != 2'b11), PC steps by 2, C.J/C.JAL/C.BEQZ/C.BNEZ/C.JR/C.JALR predecoded.
- Undefined: every word treated as 32-bit, PC steps by 4, deq_is_rvc_out tied 0, compressed predecode logic absent.

Decomposition:
- Shared constants file: opcode constants (OPC_JAL, OPC_JALR, OPC_BRANCH), RVC funct3 codes, REG_NUM_WIDTH, state encodings FETCH/WAIT_REG.
- One sub-module, fq_predecode: combinational. Takes instr, pc, rf value and taken. Produces is_rvc, class, target, next_pc, rs.

Test Plan:
- Reset with RESET_PC=32'h100; hold ic_valid_in=1 with ADDI words, deq_ready_in=0 -> ic_pc_out 100,104,...,11C; count_out reaches 8; ic_req_out drops; pc holds 120.
- Queue full, deq_ready_in=1 for 1 cycle -> exactly one dequeue; next cycle one enqueue; count stays 8 at steady state, never 9.
- JAL imm=-8 at pc 0x40 -> next ic_pc_out 0x38, deq_target_out=0x38, taken=1. BEQ imm=+16 at 0x50 with pred_taken=0 -> next pc 0x54, target 0x60.
- JALR x5, imm 4, busy=1 for 3 cycles, x5=0x201 -> rs_jalr_out=5; ic_req_out=0 for 3 cycles; then enqueue; pc=0x204.
- Flush with count=5 in WAIT_REG, flush_pc_in=0x800 -> next cycle count 0, deq_valid_out=0, state FETCH, ic_pc_out=0x800.
- FQU_RVC_EN on: C.ADDI at 0x10 then C.J imm=+6 at 0x12 -> pcs 0x10, 0x12, 0x18; deq_is_rvc_out=1 for both.
